button_debouncer: RTL and testbench

Debounces a bank of raw push-button inputs using the slow square wave produced by the divided-clock prescaler as its sample strobe. Sits directly downstream of the prescaler: the prescaler's output feeds `sample_clk`, and this block turns each rising edge into a one-cycle sample tick. Outputs are a clean per-button level plus single-cycle press and release pulses for the control logic.

---
 rtl/button_debouncer_pkg.sv | 32 +++
 rtl/button_debouncer_channel.sv | 124 ++++++++++++
 rtl/button_debouncer.sv | 54 +++++
 tb/tb_button_debouncer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared constants and types for the push-button debouncer and its
// upstream prescaler.
package button_debouncer_pkg;

  // Board oscillator frequency in Hz. The prescaler divides this down to
  // produce sample_clk, and the top level uses it when picking a sample rate.
  localparam int unsigned F_OSC = 32'd25175000;

  // Nominal debounce sample rate in Hz (one sample per millisecond).
  localparam int unsigned F_SAMPLE_DEFAULT = 32'd1000;

  // Per-channel counter phase: IDLE while the input agrees with the accepted
  // level, PENDING while a run of disagreeing samples is being counted.
  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_PENDING = 1'b1
  } ch_phase_e;

  // Prescaler division ratio for a requested sample frequency. A zero request
  // maps to the largest ratio instead of dividing by zero.
  function automatic int unsigned sample_divider(input int unsigned f_osc,
                                                 input int unsigned f_sample);
    int unsigned div;
    if (f_sample == 32'd0) begin
      div = f_osc;
    end else begin
      div = f_osc / f_sample;
    end
    return div;
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounce channel: two-flop input synchronizer, agreement counter and
// the accepted level, plus registered press/release pulses.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clkin,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_state,
  output logic btn_press,
  output logic btn_release
);

  // Counter just wide enough to hold 0..STABLE_SAMPLES.
  localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic             sync_meta_q, sync_meta_d;
  logic             sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  ch_phase_e        phase_s;
  logic             accept_s;

  // Synchronizer next values: raw input shifts through two flops.
  always_comb begin
    sync_meta_d = btn_raw;
    sync_d      = sync_meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clkin) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
    end
  end

  // Counter phase decode; a nonzero count means a candidate level is pending.
  always_comb begin
    if (cnt_q == CNT_ZERO) begin
      phase_s = CH_IDLE;
    end else begin
      phase_s = CH_PENDING;
    end
  end

  // Next-state logic: count disagreeing ticks, accept on the last one, and
  // restart whenever a sample agrees with the accepted level.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    accept_s  = 1'b0;
    if (tick) begin
      if (sync_q == state_q) begin
        cnt_d = CNT_ZERO;
      end else begin
        case (phase_s)
          CH_IDLE: begin
            // With a single required sample the first disagreement accepts.
            if (CNT_LAST == CNT_ZERO) begin
              accept_s = 1'b1;
            end else begin
              cnt_d = CNT_ONE;
            end
          end
          CH_PENDING: begin
            if (cnt_q >= CNT_LAST) begin
              accept_s = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            cnt_d = CNT_ZERO;
          end
        endcase
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (accept_s) begin
      state_d   = sync_q;
      cnt_d     = CNT_ZERO;
      press_d   = sync_q;
      release_d = ~sync_q;
    end else begin
      state_d = state_q;
    end
  end

  // Counter, accepted level and pulse registers; reset wins over any tick.
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt_q     <= CNT_ZERO;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer bank. Turns each rising edge of the prescaler's
// sample_clk into a one-cycle tick shared by all channels.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N_BUTTONS      = 4,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 sample_clk,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_state,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  // sample_clk already lives in the clkin domain, so it is only delayed one
  // cycle for edge detection, never synchronized.
  logic sample_q, sample_d;
  logic tick_s;

  // Edge-detect delay input.
  always_comb begin
    sample_d = sample_clk;
  end

  // Previous sample_clk level; resets high so a sample_clk that is already
  // high when reset drops does not look like a fresh rising edge.
  always_ff @(posedge clkin) begin
    if (rst) begin
      sample_q <= 1'b1;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign tick_s = sample_clk & ~sample_q;

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_ch (
      .clkin      (clkin),
      .rst        (rst),
      .tick       (tick_s),
      .btn_raw    (btn_raw[gi]),
      .btn_state  (btn_state[gi]),
      .btn_press  (btn_press[gi]),
      .btn_release(btn_release[gi])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed testbench for button_debouncer (4 buttons, 4 samples) with a
// second single-sample instance alongside.
module tb_button_debouncer;

  logic       clkin;
  logic       rst;
  logic       sample_clk;
  logic [3:0] btn_raw;
  logic [3:0] btn_state, btn_press, btn_release;
  logic [1:0] s1_state, s1_press, s1_release;

  int checks;
  int failures;
  int tick_n;
  int ph;
  bit sample_run;
  logic sclk_prev;
  int press_cnt [4];
  int release_cnt [4];
  int mutex_err;

  button_debouncer #(.N_BUTTONS(4), .STABLE_SAMPLES(4)) u_dut (
    .clkin(clkin), .rst(rst), .sample_clk(sample_clk), .btn_raw(btn_raw),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release)
  );

  button_debouncer #(.N_BUTTONS(2), .STABLE_SAMPLES(1)) u_dut1 (
    .clkin(clkin), .rst(rst), .sample_clk(sample_clk), .btn_raw(btn_raw[1:0]),
    .btn_state(s1_state), .btn_press(s1_press), .btn_release(s1_release)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: note whether this edge is a tick, sample outputs #1 after the
  // edge, then advance the 8-cycle sample_clk pattern.
  task automatic cyc();
    logic edge_tick;
    edge_tick = sample_clk & ~sclk_prev & ~rst;
    @(posedge clkin);
    #1;
    if (edge_tick) tick_n++;
    sclk_prev = rst ? 1'b1 : sample_clk;
    for (int i = 0; i < 4; i++) begin
      press_cnt[i]   += int'(btn_press[i]);
      release_cnt[i] += int'(btn_release[i]);
    end
    if ((btn_press & btn_release) != 4'b0000) mutex_err++;
    if ((s1_press & s1_release) != 2'b00) mutex_err++;
    if (sample_run) begin
      ph = (ph + 1) % 8;
      sample_clk = (ph < 4) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic wait_ticks(input int n);
    int start;
    int budget;
    start = tick_n;
    budget = 0;
    while ((tick_n - start) < n && budget < 200) begin
      cyc();
      budget++;
    end
    if ((tick_n - start) < n) check_eq("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      release_cnt[i] = 0;
    end
  endtask

  initial begin
    checks = 0; failures = 0; tick_n = 0; ph = 0; mutex_err = 0;
    sample_run = 1'b0;
    sclk_prev = 1'b1;
    sample_clk = 1'b1;
    btn_raw = 4'b0000;
    rst = 1'b1;
    clear_counts();

    // Reset defaults: three reset cycles with sample_clk high.
    repeat (3) cyc();
    rst = 1'b0;
    sample_run = 1'b1;
    check_eq("rst_state", 32'(btn_state), 32'h0);
    check_eq("rst_press", 32'(btn_press), 32'h0);
    check_eq("rst_release", 32'(btn_release), 32'h0);
    repeat (2) cyc();
    check_eq("post_rst_state", 32'(btn_state), 32'h0);
    check_eq("post_rst_pulses", 32'({btn_press, btn_release}), 32'h0);

    // Clean press on button 0.
    wait_ticks(1);
    clear_counts();
    btn_raw[0] = 1'b1;
    wait_ticks(3);
    check_eq("press0_early_state", 32'(btn_state), 32'h0);
    check_eq("press0_early_pulse", 32'(press_cnt[0]), 32'd0);
    wait_ticks(1);
    check_eq("press0_state", 32'(btn_state), 32'h1);
    check_eq("press0_pulse", 32'(btn_press), 32'h1);
    check_eq("press0_no_release", 32'(btn_release), 32'h0);
    check_eq("ss1_follow0", 32'(s1_state), 32'h1);
    cyc();
    check_eq("press0_pulse_end", 32'(btn_press), 32'h0);
    check_eq("press0_pulse_count", 32'(press_cnt[0]), 32'd1);

    // Bounce rejection on button 1.
    clear_counts();
    btn_raw[1] = 1'b1;
    wait_ticks(2);
    check_eq("ss1_follow1", 32'(s1_state), 32'h3);
    btn_raw[1] = 1'b0;
    wait_ticks(1);
    check_eq("ss1_bounce", 32'(s1_state), 32'h1);
    btn_raw[1] = 1'b1;
    wait_ticks(3);
    check_eq("bounce_early_state", 32'(btn_state), 32'h1);
    wait_ticks(1);
    check_eq("bounce_state", 32'(btn_state), 32'h3);
    check_eq("bounce_pulse", 32'(btn_press), 32'h2);
    cyc();
    check_eq("bounce_pulse_count", 32'(press_cnt[1]), 32'd1);

    // Buttons 2 and 3 pressed, then released together.
    btn_raw[3:2] = 2'b11;
    wait_ticks(4);
    check_eq("dual_press_state", 32'(btn_state), 32'hF);
    check_eq("dual_press_pulse", 32'(btn_press), 32'hC);
    clear_counts();
    btn_raw[3:2] = 2'b00;
    wait_ticks(3);
    check_eq("dual_rel_early", 32'(btn_state), 32'hF);
    wait_ticks(1);
    check_eq("dual_rel_pulse", 32'(btn_release), 32'hC);
    check_eq("dual_rel_state", 32'(btn_state), 32'h3);
    check_eq("dual_rel_no_press", 32'(btn_press), 32'h0);
    cyc();
    check_eq("dual_rel_end", 32'(btn_release), 32'h0);

    // Release everything, then reset in the middle of a count.
    btn_raw = 4'b0000;
    wait_ticks(4);
    check_eq("all_rel_pulse", 32'(btn_release), 32'h3);
    check_eq("all_rel_state", 32'(btn_state), 32'h0);
    btn_raw[0] = 1'b1;
    wait_ticks(3);
    rst = 1'b1;
    cyc();
    check_eq("midrst_outputs", 32'({btn_state, btn_press, btn_release}), 32'h0);
    rst = 1'b0;
    clear_counts();
    cyc();
    check_eq("midrst_after", 32'({btn_state, btn_press, btn_release}), 32'h0);
    wait_ticks(3);
    check_eq("midrst_early_state", 32'(btn_state), 32'h0);
    check_eq("midrst_early_pulse", 32'(press_cnt[0]), 32'd0);
    wait_ticks(1);
    check_eq("midrst_state", 32'(btn_state), 32'h1);
    check_eq("midrst_pulse", 32'(btn_press), 32'h1);
    cyc();

    // Idle sample clock: raw inputs churn but nothing may change.
    sample_run = 1'b0;
    sample_clk = 1'b0;
    clear_counts();
    for (int i = 0; i < 100; i++) begin
      btn_raw = 4'(i * 5 + 3);
      cyc();
    end
    check_eq("idle_state", 32'(btn_state), 32'h1);
    check_eq("idle_ss1_state", 32'(s1_state), 32'h1);
    check_eq("idle_pulses", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                                + release_cnt[0] + release_cnt[1] + release_cnt[2] + release_cnt[3]), 32'd0);
    check_eq("mutex", 32'(mutex_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
